// File: rtl/tft_pkg.sv
// Shared definitions for the TFT display path: pixel width, default panel
// geometry and the line-fetch FSM state encoding.
package tft_pkg;

  localparam int RGB_W         = 16;
  localparam int H_ACTIVE_DEF  = 800;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BURST_LEN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_RECV  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/tft_fifo_fwft.sv
// Single-clock show-ahead pixel FIFO: the head word is visible before the pop,
// pushes into a full FIFO and pops from an empty one are ignored.
module tft_fifo_fwft #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                     clk33m,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clk33m) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tft_line_fetch.sv
// Frame-buffer reader for the TFT panel: issues fixed-length read bursts while
// the pixel FIFO has room and feeds the timing block one pixel per data-enable.
module tft_line_fetch
  import tft_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 20
) (
  input  logic              clk33m,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              frame_start,
  input  logic              tft_de,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [RGB_W-1:0]  mem_rdata,
  output logic [RGB_W-1:0]  data_out,
  output logic              underflow
);

  localparam int TOTAL_BURSTS = (H_ACTIVE * V_ACTIVE) / BURST_LEN;
  localparam int BURSTS_W     = $clog2(TOTAL_BURSTS + 1);
  localparam int BEAT_W       = $clog2(BURST_LEN) + 1;
  localparam int OCC_W        = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t        state;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [BURSTS_W-1:0] bursts_left;
  logic [BEAT_W-1:0]   beat_cnt;

  logic [RGB_W-1:0]    fifo_head;
  logic                fifo_empty;
  logic                fifo_full;
  logic [OCC_W-1:0]    fifo_count;
  logic                fifo_push;
  logic                fifo_pop;
  logic                room_for_burst;
  logic                last_beat;

  assign room_for_burst = (fifo_count <= OCC_W'(FIFO_DEPTH - BURST_LEN));
  assign last_beat      = mem_rvalid && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign fifo_push      = (state == ST_RECV) && mem_rvalid && !fifo_full && !frame_start;
  assign fifo_pop       = tft_de && !frame_start;

  assign mem_req  = (state == ST_REQ);
  assign mem_addr = fetch_addr;
  assign data_out = fifo_empty ? '0 : fifo_head;

  tft_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_W)
  ) u_fifo (
    .clk33m    (clk33m),
    .rst_n     (rst_n),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // A frame_start mid-burst cannot cancel beats already granted by memory, so
  // they are counted off in DRAIN instead of landing in the fresh frame.
  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch_addr  <= '0;
      bursts_left <= '0;
      beat_cnt    <= '0;
    end else if (frame_start) begin
      fetch_addr  <= frame_base;
      bursts_left <= BURSTS_W'(TOTAL_BURSTS);
      case (state)
        ST_REQ: begin
          if (mem_ack) begin
            state    <= ST_DRAIN;
            beat_cnt <= '0;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_RECV, ST_DRAIN: begin
          if (last_beat) begin
            state <= ST_CHECK;
          end else begin
            state <= ST_DRAIN;
            if (mem_rvalid) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_CHECK;
      endcase
    end else begin
      case (state)
        ST_CHECK: begin
          if (bursts_left == '0) begin
            state <= ST_IDLE;
          end else if (room_for_burst) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state       <= ST_RECV;
            fetch_addr  <= fetch_addr + ADDR_W'(BURST_LEN);
            bursts_left <= bursts_left - 1'b1;
            beat_cnt    <= '0;
          end
        end
        ST_RECV, ST_DRAIN: begin
          if (last_beat) begin
            state <= ST_CHECK;
          end else if (mem_rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (frame_start) begin
      underflow <= 1'b0;
    end else if (tft_de && fifo_empty) begin
      underflow <= 1'b1;
    end
  end

endmodule
